// File: rtl/cdc_in_arbiter_pkg.sv
// Shared types and defaults for the USB CDC bulk IN stream arbiter.
// Holds the FSM encoding and default parameter values.
package cdc_in_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_MAX_BURST    = 64;
  localparam int DEF_IDLE_TIMEOUT = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_in_arbiter_if.sv
// Requester/usb_cdc IN side bundle for the CDC IN arbiter.
// slave is the arbiter view, master is the producers+usb_cdc view.
interface cdc_in_arbiter_if #(
  parameter int N_REQ = cdc_in_arbiter_pkg::DEF_N_REQ
);

  logic [8*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]   req_valid_i;
  logic [N_REQ-1:0]   req_last_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [7:0]         in_data_o;
  logic               in_valid_o;
  logic               in_ready_i;
  logic [N_REQ-1:0]   grant_o;
  logic               busy_o;

  modport slave (
    input  req_data_i,
    input  req_valid_i,
    input  req_last_i,
    input  in_ready_i,
    output req_ready_o,
    output in_data_o,
    output in_valid_o,
    output grant_o,
    output busy_o
  );

  modport master (
    output req_data_i,
    output req_valid_i,
    output req_last_i,
    output in_ready_i,
    input  req_ready_o,
    input  in_data_o,
    input  in_valid_o,
    input  grant_o,
    input  busy_o
  );

endinterface

// File: rtl/cdc_in_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above
// the pointer, wrapping around.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction

  logic          hit;
  logic [IW-1:0] sel;
  logic [N-1:0]  onehot;

  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    onehot = '0;
    for (int i = 1; i <= N; i++) begin
      if (!hit && req_i[wrap(int'(ptr_i) + i)]) begin
        hit = 1'b1;
        sel = wrap(int'(ptr_i) + i);
      end
    end
    if (hit) onehot[sel] = 1'b1;
  end

  assign pick_o  = onehot;
  assign idx_o   = sel;
  assign found_o = hit;

endmodule

// File: rtl/cdc_in_arbiter.sv
// Round-robin arbiter sharing the usb_cdc bulk IN byte stream.
// Grant is held per message; released on last, burst limit or idle gap.
module cdc_in_arbiter
  import cdc_in_arbiter_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input logic              clk_i,
  input logic              rstn_i,
  cdc_in_arbiter_if.slave  bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    g_q, g_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [TW-1:0]    idle_q, idle_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             found;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .found_o (found)
  );

  logic             gv;
  logic             gl;
  logic [7:0]       gdata;
  logic             xfer;
  logic             rel;
  logic [BW-1:0]    burst_nx;
  logic [TW-1:0]    idle_nx;
  logic [7:0]       in_data;
  logic             in_valid;
  logic [N_REQ-1:0] req_ready;
  logic             busy;

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    burst_d   = burst_q;
    idle_d    = idle_q;
    gv        = bus.req_valid_i[g_q];
    gl        = bus.req_last_i[g_q];
    gdata     = bus.req_data_i[{g_q, 3'b000} +: 8];
    xfer      = 1'b0;
    rel       = 1'b0;
    burst_nx  = burst_q;
    idle_nx   = idle_q;
    in_data   = '0;
    in_valid  = 1'b0;
    req_ready = '0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          g_d     = pick_idx;
          ptr_d   = pick_idx;
          gnt_d   = pick;
        end
      end
      ST_GRANT: begin
        busy           = 1'b1;
        in_valid       = gv;
        in_data        = gdata;
        req_ready[g_q] = bus.in_ready_i;
        xfer           = gv & bus.in_ready_i;
        burst_nx       = burst_q + BW'(xfer);
        // a stalled but valid requester is not idle
        if (gv)
          idle_nx = '0;
        else if (idle_q != TW'(IDLE_TIMEOUT))
          idle_nx = idle_q + 1'b1;
        rel = (xfer && gl)
            || (xfer && burst_nx == BW'(MAX_BURST))
            || (idle_nx == TW'(IDLE_TIMEOUT));
        if (rel) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          burst_d = '0;
          idle_d  = '0;
        end else begin
          burst_d = burst_nx;
          idle_d  = idle_nx;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      gnt_q   <= '0;
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.in_data_o   = in_data;
  assign bus.in_valid_o  = in_valid;
  assign bus.req_ready_o = req_ready;
  assign bus.grant_o     = gnt_q;
  assign bus.busy_o      = busy;

endmodule
